butterfly_fetch: RTL and testbench
==================================

# butterfly_fetch

Instruction fetch unit for the ButterFly RV32IM core. It issues sequential word-aligned requests to instruction memory and buffers in-order responses in a small FIFO. It presents {pc, instr} to the decoder over a valid/ready handshake. It also accepts a redirect from execute for jumps, taken branches and traps; on a redirect it flushes buffered and in-flight instructions.

## Interface
- RESET_PC, default 32'h0000_0000: first fetch address after reset; low two bits are ignored.
- FIFO_DEPTH, default 4: instruction buffer entries; must be a power of two and at least 2.
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  word-aligned fetch address; bits [1:0] are always 0.
- imem_rsp_valid  in  1  response valid; responses are in order, arrive at least 1 cycle after acceptance, and have no backpressure.
- imem_rsp_data  in  32  fetched instruction.
- redirect_valid  in  1  flush and restart at redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] are forced to 0.
- if_valid  out  1  FIFO head is valid toward decode.
- if_ready  in  1  decode consumes the head this cycle.
- if_pc  out  32  PC of the head entry.
- if_instr  out  32  instruction of the head entry.
- if_is_branch  out  1  predecode flag: opcode is OPCODE_BRANCH (present only with the macro).
- if_is_jump  out  1  predecode flag: opcode is OPCODE_JAL or OPCODE_JALR (present only with the macro).

## Operation
- FSM states:
  - BOOT: one cycle after reset release; no requests issued.
  - RUN: normal fetch.
  - FLUSH: drop_cnt > 0; stale responses are being discarded.
- Transitions:
  - BOOT→RUN unconditionally.
  - RUN→FLUSH on a redirect when the post-cycle outstanding count is greater than 0.
  - FLUSH→RUN when drop_cnt reaches 0.
  - A redirect in FLUSH stays in FLUSH and reloads drop_cnt.
- Credit rule: imem_req_valid = (state != BOOT) && (outstanding + fifo_count < FIFO_DEPTH). It depends on registered state only and never combinationally on redirect_valid.
- A request fires when imem_req_valid && imem_req_ready. On fire, fetch_pc += 4 modulo 2^32, so 0xFFFF_FFFC wraps to 0x0000_0000.
- Response path:
  - A response decrements outstanding.
  - If drop_cnt > 0, the response is discarded and drop_cnt decrements.
  - Otherwise {req_pc_queue head, imem_rsp_data} is pushed into the FIFO.
- Redirect cycle:
  - The FIFO is emptied and any dequeue that cycle is ignored.
  - fetch_pc is set to redirect_pc & ~3.
  - drop_cnt is set to the outstanding count after this cycle's fire and response. A request firing in the redirect cycle carries the old address and is counted as stale.
  - A response arriving in the redirect cycle is discarded.
- FLUSH continues issuing new requests under the credit rule; the first drop_cnt responses are discarded.
- Counters (outstanding, fifo_count, drop_cnt) are $clog2(FIFO_DEPTH)+1 bits wide and can never overflow under the credit rule.

## Timing
- Reset values:
  - imem_req_valid=0, imem_req_addr=RESET_PC&~3.
  - if_valid=0, if_pc=0, if_instr=0.
  - Predecode flags 0.
  - FSM=BOOT; all counters 0.
- First request is asserted 1 cycle after reset deassertion.
- Latency from imem_rsp_valid to if_valid: 1 cycle, because the FIFO is written and the head is registered.
- Throughput: 1 instruction/cycle with zero-wait memory and if_ready held high.
- Full FIFO: requests stop; in-flight responses always fit in the FIFO.
- Empty FIFO with if_ready=1: no effect.
- Simultaneous push and pop: both occur and fifo_count is unchanged.
- Reset asserted mid-operation: all state clears immediately, including in-flight bookkeeping. Memory must also be reset, since pre-reset responses are not dropped.
- When if_valid=0, if_pc and if_instr hold their last values; consumers must ignore them.

## Configuration
- BUTTERFLY_FETCH_PREDECODE_EN:
  - Defined: the FIFO stores two extra bits per entry, computed at push from imem_rsp_data[6:0], and drives if_is_branch/if_is_jump.
  - Undefined: the ports are absent and no predecode logic exists.

## Structure
- butterfly_pkg adds:
  - typedef fetch_entry_t {word_t pc; word_t instr;}.
  - fetch_state_e {FS_BOOT, FS_RUN, FS_FLUSH}.
  - localparam RESET_PC_DEFAULT.
- The existing OPCODE_* constants are reused for predecode.
- Sub-module butterfly_fetch_fifo: a parameterised synchronous FIFO with a flush input, instantiated for instruction entries. A small address queue of the same depth tracks PCs of outstanding requests.

## Test plan
- Reset with RESET_PC=0x100, zero-wait memory, if_ready=1 → if_pc sequence 0x100, 0x104, 0x108, one per cycle after the initial latency.
- Hold if_ready=0 → exactly FIFO_DEPTH entries are buffered and imem_req_valid drops to 0. Release if_ready → entries drain in order with no loss.
- Memory latency 3 cycles with 3 requests in flight, redirect to 0x2000 → the 3 stale responses are discarded and the next if_pc is 0x2000.
- Redirect coinciding with a request fire and a response → the fired request is dropped, the response is discarded, and fetch resumes at redirect_pc.
- Redirect to 0xFFFF_FFFE → addresses 0xFFFF_FFFC, then 0x0000_0000.
- With the macro defined, feed 0x0000_006F then 0x0000_0063 → if_is_jump=1 for the first and if_is_branch=1 for the second.

Source files
------------

// File: rtl/butterfly_pkg.sv
// butterfly_pkg: shared types, opcodes and fetch-unit definitions for the ButterFly RV32IM core
package butterfly_pkg;
    typedef logic [31:0] word_t;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;
    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;
    typedef enum logic [1:0] {FS_BOOT, FS_RUN, FS_FLUSH} fetch_state_e;
endpackage

// File: rtl/butterfly_fetch_fifo.sv
// butterfly_fetch_fifo: synchronous FIFO with flush and a registered head that holds its last value when empty
module butterfly_fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_din,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_dout,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_dout;
    logic [AW-1:0]    r_rd, r_wr, w_rd_n;
    logic [CW-1:0]    r_cnt, w_cnt_n;
    logic             w_pop, w_push;

    assign w_pop   = i_pop && r_cnt != '0;
    assign w_push  = i_push && (r_cnt != FULL || w_pop);
    assign w_rd_n  = r_rd + AW'(w_pop);
    assign w_cnt_n = r_cnt + CW'(w_push) - CW'(w_pop);
    assign o_dout  = r_dout;
    assign o_count = r_cnt;

    // storage write; contents need no reset since the head register gates visibility
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr] <= i_din;
    end

    // pointers, occupancy and the registered head (bypass when the pushed entry becomes the head)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd   <= '0;
            r_wr   <= '0;
            r_cnt  <= '0;
            r_dout <= '0;
        end else if (i_flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            r_rd  <= w_rd_n;
            r_wr  <= r_wr + AW'(w_push);
            r_cnt <= w_cnt_n;
            if (w_cnt_n != '0) r_dout <= (w_push && w_rd_n == r_wr) ? i_din : r_mem[w_rd_n];
        end
    end
endmodule

// File: rtl/butterfly_fetch.sv
// butterfly_fetch: credit-based instruction fetch with redirect flush; BUTTERFLY_FETCH_PREDECODE_EN adds branch/jump predecode
module butterfly_fetch
    import butterfly_pkg::*;
#(
    parameter word_t RESET_PC   = RESET_PC_DEFAULT,
    parameter int    FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
`ifdef BUTTERFLY_FETCH_PREDECODE_EN
    ,
    output logic        if_is_branch,
    output logic        if_is_jump
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);
`ifdef BUTTERFLY_FETCH_PREDECODE_EN
    localparam int EW = $bits(fetch_entry_t) + 2;
`else
    localparam int EW = $bits(fetch_entry_t);
`endif
    fetch_state_e  r_state;
    word_t         r_fetch_pc;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] w_outstanding, w_fifo_cnt, w_out_n, w_drop_n;
    logic [CW:0]   w_used;
    logic          w_fire, w_push;
    word_t         w_rsp_pc;
    fetch_entry_t  w_push_ent, w_head_ent;
    logic [EW-1:0] w_din, w_dout;

    assign w_used         = {1'b0, w_outstanding} + {1'b0, w_fifo_cnt};
    assign imem_req_valid = (r_state != FS_BOOT) && (w_used < DEPTH_W);
    assign imem_req_addr  = r_fetch_pc;
    assign w_fire         = imem_req_valid && imem_req_ready;
    assign w_out_n        = w_outstanding + CW'(w_fire) - CW'(imem_rsp_valid);
    assign w_drop_n       = redirect_valid ? w_out_n : r_drop_cnt - CW'(imem_rsp_valid && r_drop_cnt != '0);
    assign w_push         = imem_rsp_valid && r_drop_cnt == '0 && !redirect_valid;
    assign w_push_ent     = '{pc: w_rsp_pc, instr: imem_rsp_data};
`ifdef BUTTERFLY_FETCH_PREDECODE_EN
    assign w_din = {imem_rsp_data[6:0] == OPCODE_BRANCH,
                    imem_rsp_data[6:0] == OPCODE_JAL || imem_rsp_data[6:0] == OPCODE_JALR,
                    w_push_ent};
    assign {if_is_branch, if_is_jump, w_head_ent} = w_dout;
`else
    assign w_din      = w_push_ent;
    assign w_head_ent = w_dout;
`endif
    assign if_pc    = w_head_ent.pc;
    assign if_instr = w_head_ent.instr;
    assign if_valid = w_fifo_cnt != '0;

    // fetch FSM: state follows whether stale responses remain to be dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= FS_BOOT;
            r_fetch_pc <= RESET_PC & ~32'd3;
            r_drop_cnt <= '0;
        end else begin
            r_state    <= (w_drop_n != '0) ? FS_FLUSH : FS_RUN;
            r_fetch_pc <= redirect_valid ? (redirect_pc & ~32'd3) : r_fetch_pc + (w_fire ? 32'd4 : 32'd0);
            r_drop_cnt <= w_drop_n;
        end
    end

    // PCs of outstanding requests; its occupancy is the outstanding count
    butterfly_fetch_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_pcq (
        .clk     (clk),
        .rst     (rst),
        .i_flush (1'b0),
        .i_push  (w_fire),
        .i_din   (r_fetch_pc),
        .i_pop   (imem_rsp_valid),
        .o_dout  (w_rsp_pc),
        .o_count (w_outstanding)
    );

    // instruction buffer toward decode, emptied on redirect
    butterfly_fetch_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_ibuf (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (if_ready),
        .o_dout  (w_dout),
        .o_count (w_fifo_cnt)
    );
endmodule

// File: tb/tb_butterfly_fetch.sv
// tb_butterfly_fetch: directed bench with a stream-level fetch model and a latency-configurable memory
module tb_butterfly_fetch;
    logic        clk = 0, rst = 1;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_req_addr, imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid, if_ready;
    logic [31:0] if_pc, if_instr;
    logic        if_is_branch, if_is_jump;

    typedef struct {logic [31:0] addr; int due;} mreq_t;
    typedef struct {logic [31:0] pc; logic [31:0] instr; logic br; logic jmp;} got_t;
    mreq_t mem_q[$];
    got_t  got[$];
    int checks = 0, failures = 0, cyc = 0, lat = 1, hs = 0;
    logic coinc = 0;
    logic [31:0] exp_pc, exp_req;

    butterfly_fetch #(.RESET_PC(32'h100), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
`ifdef BUTTERFLY_FETCH_PREDECODE_EN
        , .if_is_branch(if_is_branch), .if_is_jump(if_is_jump)
`endif
    );
`ifndef BUTTERFLY_FETCH_PREDECODE_EN
    assign if_is_branch = 1'b0;
    assign if_is_jump   = 1'b0;
`endif

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(logic [31:0] a);
        if (a == 32'h3000) return 32'h0000_006F;
        if (a == 32'h3004) return 32'h0000_0063;
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_got(int n);
        for (int i = 0; i < 100 && got.size() < n; i++) step(1);
        chk("got_timeout", got.size() >= n, 1);
    endtask

    task automatic redirect(logic [31:0] pc);
        got.delete();
        redirect_valid = 1;
        redirect_pc = pc;
        step(1);
        redirect_valid = 0;
    endtask

    // memory: in-order responses, each due lat cycles after acceptance
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            mem_q.delete();
            imem_rsp_valid = 0;
            imem_rsp_data = 0;
        end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1;
            imem_rsp_data = mem_data(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else imem_rsp_valid = 0;
    end

    // stream model: requests and deliveries each walk +4 from reset or redirect target
    always @(negedge clk) begin
        if (rst) begin
            exp_pc = 32'h100;
            exp_req = 32'h100;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                chk("req_addr", imem_req_addr, exp_req);
                exp_req += 4;
                mem_q.push_back('{imem_req_addr, cyc + lat});
            end
            if (redirect_valid) begin
                coinc = imem_req_valid && imem_req_ready && imem_rsp_valid;
                exp_req = redirect_pc & ~32'd3;
                exp_pc = redirect_pc & ~32'd3;
            end else if (if_valid && if_ready) begin
                chk("if_pc", if_pc, exp_pc);
                chk("if_instr", if_instr, mem_data(exp_pc));
`ifdef BUTTERFLY_FETCH_PREDECODE_EN
                chk("if_is_branch", if_is_branch, mem_data(exp_pc) == 32'h63);
                chk("if_is_jump", if_is_jump, mem_data(exp_pc) == 32'h6F);
`endif
                got.push_back('{if_pc, if_instr, if_is_branch, if_is_jump});
                exp_pc += 4;
                hs++;
            end
        end
    end

    initial begin
        imem_req_ready = 1;
        if_ready = 1;
        redirect_valid = 0;
        redirect_pc = 0;
        step(3);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_req_addr", imem_req_addr, 32'h100);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_if_pc", if_pc, 0);
        chk("rst_if_instr", if_instr, 0);
        rst = 0;
        step(12);
        chk("seq_pc0", got[0].pc, 32'h100);
        chk("seq_pc1", got[1].pc, 32'h104);
        chk("seq_pc2", got[2].pc, 32'h108);
        chk("seq_instr0", got[0].instr, 32'h5A5A_0100);
        hs = 0;
        step(8);
        chk("throughput", hs, 8);
        if_ready = 0;
        step(12);
        chk("full_if_valid", if_valid, 1);
        chk("full_req_valid", imem_req_valid, 0);
        chk("full_req_addr", imem_req_addr, if_pc + 32'd16);
        if_ready = 1;
        step(10);
        lat = 3;
        step(12);
        redirect(32'h2000);
        wait_got(2);
        chk("redir_pc0", got[0].pc, 32'h2000);
        chk("redir_pc1", got[1].pc, 32'h2004);
        lat = 1;
        step(10);
        coinc = 0;
        redirect(32'h4000);
        chk("coincide", coinc, 1);
        wait_got(1);
        chk("coinc_pc", got[0].pc, 32'h4000);
        redirect(32'hFFFF_FFFE);
        wait_got(2);
        chk("wrap_pc0", got[0].pc, 32'hFFFF_FFFC);
        chk("wrap_pc1", got[1].pc, 32'h0000_0000);
        redirect(32'h3000);
        wait_got(2);
        chk("pd_instr0", got[0].instr, 32'h6F);
        chk("pd_instr1", got[1].instr, 32'h63);
`ifdef BUTTERFLY_FETCH_PREDECODE_EN
        chk("pd_jump0", got[0].jmp, 1);
        chk("pd_branch1", got[1].br, 1);
`endif
        step(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
